lcd_nibble_seq: RTL and testbench
=================================

Name: lcd_nibble_seq

Overview:
- Sequencer for the on-board character LCD (HD44780-compatible, 4-bit bus, write-only).
- After reset it runs the power-on init and configuration sequence. It then accepts byte commands and characters from the datapath (e.g. adder result display) over a valid/ready handshake.
- For each accepted byte it drives two nibble writes with correct setup, enable-pulse and settle timing.

Parameters:
- T_PWRON, 750000, cycles to wait after reset before the first init nibble (15 ms @ 50 MHz)
- T_INIT1, 205000, wait after the first 0x3 init nibble (4.1 ms)
- T_INIT2, 5000, wait after the second 0x3 nibble (100 us)
- T_SETUP, 2, cycles rs/d stable before lcd_e rises
- T_EPW, 12, lcd_e high width in cycles
- T_NIB, 50, gap after the upper nibble falls before the lower nibble setup starts
- T_CMD, 2000, settle after a byte or after the third 0x3 or the 0x2 init nibble (40 us)
- T_CLR, 82000, settle after a byte equal to 0x01 or 0x02 with rs=0 (clear/home)

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  byte request present
- req_rs  input  1  0 = command, 1 = character data
- req_data  input  8  byte to write
- req_ready  output  1  high only in IDLE; a transfer occurs when req_valid & req_ready on a clk edge
- init_done  output  1  high once the configuration sequence is complete; sticky until rst
- sf_e  output  1  constant 1 (StrataFlash disabled, LCD owns the bus)
- lcd_e  output  1  LCD enable strobe
- lcd_rs  output  1  register select
- lcd_rw  output  1  constant 0 (write only)
- lcd_d  output  4  data nibble (d,c,b,a order = bits 3..0)

Behaviour:
- Reset (async, immediate) values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, sf_e=1, req_ready=0, init_done=0. State is PWRON and the wait counter is cleared.
- Reset asserted mid-operation aborts any nibble, drops lcd_e in the same instant, and restarts the full init sequence.
- States:
  - PWRON: wait T_PWRON cycles.
  - INIT: raw nibbles 0x3 (then wait T_INIT1), 0x3 (then wait T_INIT2), 0x3 (then wait T_CMD), 0x2 (then wait T_CMD). All with rs=0.
  - CFG: internal byte list 0x28, 0x06, 0x0C, 0x01. Each byte is sent as upper then lower nibble with rs=0 and follows the byte timing below; 0x01 uses T_CLR.
  - On CFG completion: init_done<=1, go to IDLE.
  - IDLE: req_ready=1. On handshake, latch req_rs and req_data into holding registers, deassert req_ready the next cycle, go to WRITE.
  - WRITE: see byte timing.
  - SETTLE: wait T_CMD, or T_CLR for a clear/home command; then return to IDLE.
- Nibble timing: drive lcd_rs and lcd_d, hold T_SETUP cycles with lcd_e=0, then lcd_e=1 for exactly T_EPW cycles, then lcd_e=0. lcd_d and lcd_rs remain stable for at least 1 cycle after lcd_e falls.
- Byte timing: upper nibble (data[7:4]), then T_NIB cycles, then lower nibble (data[3:0]), then settle.
- lcd_d and lcd_rs change only while lcd_e=0.
- Requests presented while req_ready=0 (including during init) are not consumed; the requester must hold them stable.
- Only one byte is in flight; there is no queue.
- All wait counters are 20 bits; any parameter value up to 2^20-1 is legal. A value of 0 means a single-cycle pass-through.

Optional Feature:
- LCD_HEXCONV_EN
- Defined: when req_rs=1, req_data[3:0] is converted to its ASCII hex character: values 0-9 become 0x30-0x39, values A-F become 0x41-0x46; req_data[7:4] is ignored. Commands (rs=0) pass through unchanged.
- Undefined: req_data is written verbatim for both rs values.

Test Plan (use reduced parameters T_PWRON=100, T_INIT1=40, T_INIT2=20, T_CMD=10, T_CLR=30, T_NIB=5):
- Reset release -> lcd_e pulses carry nibble sequence 3,3,3,2,2,8,0,6,0,C,0,1, all with rs=0. Each pulse is 12 cycles wide. init_done rises 30 cycles after the last pulse falls; req_ready rises with it.
- Init done, req_valid=1, rs=1, data=0x41 -> req_ready drops the next cycle. Two rs=1 pulses carry 0x4 then 0x1, with 5 cycles between the first fall and the start of the second setup. req_ready returns 10 cycles after the second fall.
- rs=0, data=0x01 -> settle is 30 cycles before req_ready returns. With data=0x0C the settle is 10 cycles.
- req_valid held high during init and during a write -> no request consumed until IDLE. Exactly one write occurs per handshake.
- rst asserted while lcd_e=1 mid-character -> lcd_e=0 immediately and init_done=0. After release the full init sequence repeats from the first 0x3 nibble.
- LCD_HEXCONV_EN defined, rs=1, data=0x0B -> nibbles 0x4, 0x2 ('B'). Data=0x07 -> nibbles 0x3, 0x7.

Source files
------------

// File: rtl/lcd_nibble_seq.sv
// rtl/lcd_nibble_seq.sv - HD44780 4-bit init/config and byte-write sequencer (option: LCD_HEXCONV_EN)
module lcd_nibble_seq #(
  parameter int T_PWRON = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 12,
  parameter int T_NIB   = 50,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       sf_e,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam logic [19:0] L_PWRON = 20'(T_PWRON);
  localparam logic [19:0] L_INIT1 = 20'(T_INIT1);
  localparam logic [19:0] L_INIT2 = 20'(T_INIT2);
  localparam logic [19:0] L_SETUP = 20'(T_SETUP);
  localparam logic [19:0] L_EPW   = 20'(T_EPW);
  localparam logic [19:0] L_NIB   = 20'(T_NIB);
  localparam logic [19:0] L_CMD   = 20'(T_CMD);
  localparam logic [19:0] L_CLR   = 20'(T_CLR);

  // seq_q: 0..3 raw init nibbles, 4..7 configuration bytes, 8 host byte
  localparam logic [3:0] SEQ_LAST_RAW = 4'd3;
  localparam logic [3:0] SEQ_CFG0     = 4'd4;
  localparam logic [3:0] SEQ_CFG_LAST = 4'd7;
  localparam logic [3:0] SEQ_USER     = 4'd8;

  typedef enum logic [2:0] {S_PWRON, S_SETUP, S_PULSE, S_WAIT, S_IDLE} state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  seq_q, seq_d;
  logic        hi_q, hi_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic [3:0]  lcd_d_q, lcd_d_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_e_q, lcd_e_d;
  logic        init_done_q, init_done_d;

  logic [19:0] wait_len, phase_len;
  logic        phase_last;
  logic [7:0]  next_cfg;
  logic [7:0]  req_byte;

  function automatic logic [7:0] cfg_byte(input logic [3:0] seq);
    case (seq)
      4'd4:    return 8'h28;
      4'd5:    return 8'h06;
      4'd6:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Byte accepted from the host, optionally mapped to an ASCII hex digit
  always_comb begin
    req_byte = req_data;
`ifdef LCD_HEXCONV_EN
    if (req_rs) begin
      if (req_data[3:0] < 4'd10) req_byte = {4'h3, req_data[3:0]};
      else                       req_byte = 8'h37 + {4'h0, req_data[3:0]};
    end
`endif
  end

  // Post-nibble wait: init ladder, inter-nibble gap, or command/clear settle
  always_comb begin
    wait_len = L_CMD;
    if (seq_q == 4'd0)                                       wait_len = L_INIT1;
    else if (seq_q == 4'd1)                                  wait_len = L_INIT2;
    else if (seq_q <= SEQ_LAST_RAW)                          wait_len = L_CMD;
    else if (hi_q)                                           wait_len = L_NIB;
    else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) wait_len = L_CLR;
  end

  // Length of the current phase; zero behaves as a single cycle
  always_comb begin
    phase_len = 20'd0;
    case (state_q)
      S_PWRON: phase_len = L_PWRON;
      S_SETUP: phase_len = L_SETUP;
      S_PULSE: phase_len = L_EPW;
      S_WAIT:  phase_len = wait_len;
      default: phase_len = 20'd0;
    endcase
    phase_last = ({1'b0, cnt_q} + 21'd1) >= {1'b0, phase_len};
    next_cfg   = cfg_byte(seq_q + 4'd1);
  end

  // Next-state logic; bus outputs only change when entering SETUP (lcd_e low)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 20'd1;
    seq_d       = seq_q;
    hi_d        = hi_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    lcd_d_d     = lcd_d_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_e_d     = lcd_e_q;
    init_done_d = init_done_q;
    case (state_q)
      S_PWRON: begin
        if (phase_last) begin
          state_d  = S_SETUP;
          cnt_d    = 20'd0;
          seq_d    = 4'd0;
          lcd_d_d  = 4'h3;
          lcd_rs_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (phase_last) begin
          state_d = S_PULSE;
          cnt_d   = 20'd0;
          lcd_e_d = 1'b1;
        end
      end
      S_PULSE: begin
        if (phase_last) begin
          state_d = S_WAIT;
          cnt_d   = 20'd0;
          lcd_e_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (phase_last) begin
          cnt_d = 20'd0;
          if (seq_q < SEQ_LAST_RAW) begin
            state_d  = S_SETUP;
            seq_d    = seq_q + 4'd1;
            lcd_d_d  = (seq_q == 4'd2) ? 4'h2 : 4'h3;
            lcd_rs_d = 1'b0;
          end else if (seq_q == SEQ_LAST_RAW) begin
            state_d  = S_SETUP;
            seq_d    = SEQ_CFG0;
            hi_d     = 1'b1;
            byte_d   = next_cfg;
            rs_d     = 1'b0;
            lcd_d_d  = next_cfg[7:4];
            lcd_rs_d = 1'b0;
          end else if (hi_q) begin
            state_d = S_SETUP;
            hi_d    = 1'b0;
            lcd_d_d = byte_q[3:0];
          end else if (seq_q < SEQ_CFG_LAST) begin
            state_d  = S_SETUP;
            seq_d    = seq_q + 4'd1;
            hi_d     = 1'b1;
            byte_d   = next_cfg;
            lcd_d_d  = next_cfg[7:4];
            lcd_rs_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            if (seq_q == SEQ_CFG_LAST) init_done_d = 1'b1;
          end
        end
      end
      S_IDLE: begin
        cnt_d = 20'd0;
        if (req_valid) begin
          state_d  = S_SETUP;
          seq_d    = SEQ_USER;
          hi_d     = 1'b1;
          byte_d   = req_byte;
          rs_d     = req_rs;
          lcd_d_d  = req_byte[7:4];
          lcd_rs_d = req_rs;
        end
      end
      default: state_d = S_PWRON;
    endcase
  end

  // State and output registers; reset aborts any nibble and restarts init
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWRON;
      cnt_q       <= 20'd0;
      seq_q       <= 4'd0;
      hi_q        <= 1'b0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      lcd_d_q     <= 4'h0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      hi_q        <= hi_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      lcd_d_q     <= lcd_d_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign init_done = init_done_q;
  assign sf_e      = 1'b1;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_d     = lcd_d_q;

endmodule

// File: tb/tb_lcd_nibble_seq.sv
// tb/tb_lcd_nibble_seq.sv - self-checking bench for lcd_nibble_seq with reduced timing
module tb_lcd_nibble_seq;

  localparam int P_PWRON = 100;
  localparam int P_INIT1 = 40;
  localparam int P_INIT2 = 20;
  localparam int P_SETUP = 2;
  localparam int P_EPW   = 12;
  localparam int P_NIB   = 5;
  localparam int P_CMD   = 10;
  localparam int P_CLR   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_nibble_seq #(
    .T_PWRON(P_PWRON), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2), .T_SETUP(P_SETUP),
    .T_EPW(P_EPW), .T_NIB(P_NIB), .T_CMD(P_CMD), .T_CLR(P_CLR)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .sf_e(sf_e), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  // Bus monitor: records every enable pulse and bus-rule violations
  typedef struct { logic rs; logic [3:0] d; int rise; int fall; } pulse_t;
  pulse_t     pq[$];
  pulse_t     cur;
  int         cyc = 0, last_chg = 0, rdy_rise = -1, done_rise = -1;
  int         setup_viol = 0, stab_viol = 0;
  logic       prev_e = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0;
  logic [4:0] prev_bus = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ({lcd_rs, lcd_d} != prev_bus) begin
      last_chg = cyc;
      if (lcd_e || prev_e) stab_viol++;
    end
    if (lcd_e && !prev_e) begin
      cur.rise = cyc; cur.rs = lcd_rs; cur.d = lcd_d;
      if (cyc - last_chg < P_SETUP) setup_viol++;
    end
    if (!lcd_e && prev_e) begin
      cur.fall = cyc;
      pq.push_back(cur);
    end
    if (req_ready && !prev_rdy) rdy_rise = cyc;
    if (init_done && !prev_done) done_rise = cyc;
    prev_e = lcd_e; prev_rdy = req_ready; prev_done = init_done;
    prev_bus = {lcd_rs, lcd_d};
  end

  // Reference: byte actually written to the LCD for a host request
  function automatic logic [7:0] model_byte(input logic rs, input logic [7:0] d);
`ifdef LCD_HEXCONV_EN
    string hex;
    hex = "0123456789ABCDEF";
    if (rs) return hex[d[3:0]];
`endif
    return d;
  endfunction

  function automatic int model_settle(input logic rs, input logic [7:0] b);
    return (!rs && (b == 8'h01 || b == 8'h02)) ? P_CLR : P_CMD;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (lcd_e !== 1'b0)     begin n_bad++; $display("FAIL reset_lcd_e: got %0b expected 0", lcd_e); end
    n_cmp++; if (lcd_rs !== 1'b0)    begin n_bad++; $display("FAIL reset_lcd_rs: got %0b expected 0", lcd_rs); end
    n_cmp++; if (lcd_rw !== 1'b0)    begin n_bad++; $display("FAIL reset_lcd_rw: got %0b expected 0", lcd_rw); end
    n_cmp++; if (lcd_d !== 4'h0)     begin n_bad++; $display("FAIL reset_lcd_d: got %0h expected 0", lcd_d); end
    n_cmp++; if (sf_e !== 1'b1)      begin n_bad++; $display("FAIL reset_sf_e: got %0b expected 1", sf_e); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %0b expected 0", req_ready); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %0b expected 0", init_done); end
  endtask

  // Releases reset and checks the whole init/config nibble stream while a request is held
  task automatic test_init();
    logic [3:0] exp_d[$];
    int         wait_after[$];
    logic [7:0] cfg[4];
    int         rel, k;
    cfg        = '{8'h28, 8'h06, 8'h0C, 8'h01};
    exp_d      = '{4'h3, 4'h3, 4'h3, 4'h2};
    wait_after = '{P_INIT1, P_INIT2, P_CMD, P_CMD};
    foreach (cfg[i]) begin
      exp_d.push_back(cfg[i][7:4]); wait_after.push_back(P_NIB);
      exp_d.push_back(cfg[i][3:0]); wait_after.push_back(model_settle(1'b0, cfg[i]));
    end
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
    pq.delete(); done_rise = -1;
    @(negedge clk);
    rst = 1'b0; rel = cyc;
    k = 0;
    while (!init_done && k < 3000) begin @(negedge clk); k++; end
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_timeout: got %0b expected 1", init_done); end
    n_cmp++; if (pq.size() != exp_d.size()) begin
      n_bad++; $display("FAIL init_pulse_count: got %0d expected %0d", pq.size(), exp_d.size());
    end else begin
      n_cmp++; if (pq[0].rise - rel != P_PWRON + P_SETUP) begin
        n_bad++; $display("FAIL init_first_rise: got %0d expected %0d", pq[0].rise - rel, P_PWRON + P_SETUP);
      end
      foreach (pq[i]) begin
        n_cmp++; if (pq[i].d !== exp_d[i] || pq[i].rs !== 1'b0) begin
          n_bad++; $display("FAIL init_nibble[%0d]: got rs=%0b d=%0h expected rs=0 d=%0h", i, pq[i].rs, pq[i].d, exp_d[i]);
        end
        n_cmp++; if (pq[i].fall - pq[i].rise != P_EPW) begin
          n_bad++; $display("FAIL init_width[%0d]: got %0d expected %0d", i, pq[i].fall - pq[i].rise, P_EPW);
        end
        if (i > 0) begin
          n_cmp++; if (pq[i].rise - pq[i-1].fall != wait_after[i-1] + P_SETUP) begin
            n_bad++; $display("FAIL init_gap[%0d]: got %0d expected %0d", i, pq[i].rise - pq[i-1].fall, wait_after[i-1] + P_SETUP);
          end
        end
      end
      n_cmp++; if (done_rise - pq[11].fall != wait_after[11]) begin
        n_bad++; $display("FAIL init_done_delay: got %0d expected %0d", done_rise - pq[11].fall, wait_after[11]);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL init_ready: got %0b expected 1", req_ready); end
    n_cmp++; if (pq.size() != 12) begin n_bad++; $display("FAIL init_no_consume: got %0d pulses expected 12", pq.size()); end
  endtask

  // One host byte: handshake, two nibbles, gap and settle timing
  task automatic test_byte(input logic rs, input logic [7:0] data);
    logic [7:0] e;
    int         hs, k, settle;
    e      = model_byte(rs, data);
    settle = model_settle(rs, e);
    k = 0;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    pq.delete();
    req_valid = 1'b1; req_rs = rs; req_data = data;
    @(negedge clk);
    hs = cyc;
    req_valid = 1'b0; req_rs = 1'($urandom); req_data = 8'($urandom);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL byte_ready_drop %0h: got %0b expected 0", data, req_ready); end
    k = 0;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    @(negedge clk);
    n_cmp++; if (pq.size() != 2) begin
      n_bad++; $display("FAIL byte_pulse_count %0h: got %0d expected 2", data, pq.size());
    end else begin
      n_cmp++; if (pq[0].d !== e[7:4] || pq[0].rs !== rs) begin
        n_bad++; $display("FAIL byte_upper %0h: got rs=%0b d=%0h expected rs=%0b d=%0h", data, pq[0].rs, pq[0].d, rs, e[7:4]);
      end
      n_cmp++; if (pq[1].d !== e[3:0] || pq[1].rs !== rs) begin
        n_bad++; $display("FAIL byte_lower %0h: got rs=%0b d=%0h expected rs=%0b d=%0h", data, pq[1].rs, pq[1].d, rs, e[3:0]);
      end
      n_cmp++; if (pq[0].rise - hs != P_SETUP || pq[0].fall - pq[0].rise != P_EPW || pq[1].fall - pq[1].rise != P_EPW) begin
        n_bad++; $display("FAIL byte_pulse_timing %0h: got setup=%0d w0=%0d w1=%0d expected %0d/%0d", data,
                          pq[0].rise - hs, pq[0].fall - pq[0].rise, pq[1].fall - pq[1].rise, P_SETUP, P_EPW);
      end
      n_cmp++; if (pq[1].rise - pq[0].fall != P_NIB + P_SETUP) begin
        n_bad++; $display("FAIL byte_nib_gap %0h: got %0d expected %0d", data, pq[1].rise - pq[0].fall, P_NIB + P_SETUP);
      end
      n_cmp++; if (rdy_rise - pq[1].fall != settle) begin
        n_bad++; $display("FAIL byte_settle %0h: got %0d expected %0d", data, rdy_rise - pq[1].fall, settle);
      end
    end
  endtask

  task automatic test_directed();
    logic [8:0] tbl[8];
    tbl = '{9'h141, 9'h001, 9'h00C, 9'h002, 9'h10B, 9'h107, 9'h080, 9'h1FF};
    foreach (tbl[i]) test_byte(tbl[i][8], tbl[i][7:0]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) test_byte(1'($urandom), 8'($urandom));
  endtask

  // req_valid stays high across several writes; each handshake yields exactly one byte
  task automatic test_back_to_back();
    logic [7:0] d[3];
    logic       r[3];
    logic [7:0] e;
    int         k;
    k = 0;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    pq.delete();
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r[i] = 1'($urandom); d[i] = 8'($urandom);
      req_rs = r[i]; req_data = d[i];
      k = 0;
      while (!req_ready && k < 1000) begin @(negedge clk); k++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    k = 0;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    n_cmp++; if (pq.size() != 6) begin
      n_bad++; $display("FAIL b2b_pulse_count: got %0d expected 6", pq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = model_byte(r[i], d[i]);
        n_cmp++; if ({pq[2*i].rs, pq[2*i].d, pq[2*i+1].rs, pq[2*i+1].d} !== {r[i], e[7:4], r[i], e[3:0]}) begin
          n_bad++; $display("FAIL b2b_byte[%0d]: got %0b/%0h%0h expected %0b/%0h", i, pq[2*i].rs, pq[2*i].d, pq[2*i+1].d, r[i], e);
        end
      end
    end
  endtask

  task automatic test_bus_rules();
    n_cmp++; if (setup_viol != 0) begin n_bad++; $display("FAIL bus_setup: got %0d violations expected 0", setup_viol); end
    n_cmp++; if (stab_viol != 0)  begin n_bad++; $display("FAIL bus_stable: got %0d violations expected 0", stab_viol); end
  endtask

  // Reset during an enable pulse: immediate abort, then full init replay
  task automatic test_reset_mid();
    int k;
    test_bus_rules();
    k = 0;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!lcd_e && k < 100) begin @(negedge clk); k++; end
    n_cmp++; if (lcd_e !== 1'b1) begin n_bad++; $display("FAIL mid_pulse_seen: got %0b expected 1", lcd_e); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (lcd_e !== 1'b0)     begin n_bad++; $display("FAIL mid_rst_lcd_e: got %0b expected 0", lcd_e); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_init_done: got %0b expected 0", init_done); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %0b expected 0", req_ready); end
    repeat (2) @(negedge clk);
    setup_viol = 0; stab_viol = 0;
    test_init();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_byte(1'b1, 8'h41);
    test_bus_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
